// File: rtl/distributor1to4_pkg.sv
// Model-computer constants shared by the write-side distributor and other T-driven blocks.
package distributor1to4_pkg;

  localparam int T_CAP    = 3;
  localparam int T_COMMIT = 5;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  localparam logic [1:0] REG0 = 2'd0;
  localparam logic [1:0] REG1 = 2'd1;
  localparam logic [1:0] REG2 = 2'd2;
  localparam logic [1:0] REG3 = 2'd3;

  function automatic logic [3:0] reg_onehot(input logic [1:0] a);
    logic [3:0] oh;
    oh = 4'b0000;
    case (a)
      REG0: oh = 4'b0001;
      REG1: oh = 4'b0010;
      REG2: oh = 4'b0100;
      REG3: oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/distributor1to4_t_edge.sv
// Rising-edge detector for the timing-pulse vector; one pulse per low-to-high transition.
module t_edge #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TW-1:0] t,
  output logic [TW-1:0] rise
);

  logic [TW-1:0] t_prev;

  // t_prev clears on reset, so a bit already high right after reset reads as an edge.
  always_ff @(posedge clk) begin
    if (rst) t_prev <= '0;
    else     t_prev <= t;
  end

  assign rise = t & ~t_prev;

endmodule

// File: rtl/distributor1to4.sv
// Write-side distributor: capture addr/DIN on a T edge, commit into one of Q0..Q3 on a later T edge.
module distributor1to4
  import distributor1to4_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int TW         = 8,
  parameter int CAP_BIT    = T_CAP,
  parameter int COMMIT_BIT = T_COMMIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TW-1:0]    T,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic [3:0]       WE,
  output logic             busy,
  output logic             ovf
);

  logic [TW-1:0]          rise;
  logic                   cap_ev, com_ev;
  logic                   unused_rise;
  state_t                 state;
  logic [1:0]             a_l;
  logic [WIDTH-1:0]       d_l;
  logic [3:0][WIDTH-1:0]  q;

  t_edge #(.TW(TW)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .t    (T),
    .rise (rise)
  );

  assign cap_ev      = rise[CAP_BIT];
  assign com_ev      = rise[COMMIT_BIT];
  assign unused_rise = ^rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_l   <= '0;
      d_l   <= '0;
      q     <= '0;
      WE    <= '0;
      busy  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      WE <= '0;
      case (state)
        IDLE: begin
          // A commit with nothing held is dropped silently.
          if (cap_ev) begin
            a_l   <= addr;
            d_l   <= DIN;
            state <= HELD;
            busy  <= 1'b1;
          end
        end
        HELD: begin
          if (com_ev) begin
            q[a_l] <= d_l;
            WE     <= reg_onehot(a_l);
          end
          if (cap_ev) begin
            // Old word is committed above before the new one replaces it.
            a_l <= addr;
            d_l <= DIN;
            if (!com_ev) ovf <= 1'b1;
          end else if (com_ev) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Q0 = q[0];
  assign Q1 = q[1];
  assign Q2 = q[2];
  assign Q3 = q[3];

endmodule

// File: tb/tb_distributor1to4.sv
// Scoreboard bench for distributor1to4: expected writes queued at commit, checked on WE.
module tb_distributor1to4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] T;
  logic [1:0] addr;
  logic [7:0] DIN;
  logic [7:0] Q0, Q1, Q2, Q3;
  logic [3:0] WE;
  logic       busy, ovf;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] data;
  } wr_t;
  wr_t sb[$];

  always #5 clk = ~clk;

  distributor1to4 dut (
    .clk(clk), .rst(rst), .T(T), .addr(addr), .DIN(DIN),
    .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3),
    .WE(WE), .busy(busy), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] qsel(input logic [1:0] i);
    case (i)
      2'd0: return Q0;
      2'd1: return Q1;
      2'd2: return Q2;
      default: return Q3;
    endcase
  endfunction

  // Advance one clock and sample 1 time unit after the edge; any WE pulse must match the queue head.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (WE !== 4'b0000) begin
      if (sb.size() == 0) begin
        chk("spurious_we", {28'd0, WE}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("we_strobe", {28'd0, WE}, {28'd0, 4'b0001 << e.idx});
        chk("q_data", {24'd0, qsel(e.idx)}, {24'd0, e.data});
      end
    end
  endtask

  task automatic expect_wr(input logic [1:0] idx, input logic [7:0] data);
    wr_t e;
    e.idx = idx;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1; T = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; T = '0; addr = '0; DIN = '0;

    // Reset state
    do_reset();
    chk("rst_q", {Q3, Q2, Q1, Q0}, 32'd0);
    chk("rst_we", {28'd0, WE}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);

    // Basic write to Q2
    addr = 2'd2; DIN = 8'hA5; T = 8'h08; tick();
    chk("basic_busy1", {31'd0, busy}, 32'd1);
    T = 8'h00; tick();
    chk("basic_busy2", {31'd0, busy}, 32'd1);
    T = 8'h20; expect_wr(2'd2, 8'hA5); tick();
    chk("basic_q2", {24'd0, Q2}, 32'hA5);
    chk("basic_busy_done", {31'd0, busy}, 32'd0);
    T = 8'h00; tick();
    chk("basic_we_clr", {28'd0, WE}, 32'd0);
    chk("basic_others", {8'd0, Q3, Q1, Q0}, 32'd0);

    // Level-held pulses: one capture and one write only
    addr = 2'd1; DIN = 8'h3C; T = 8'h08;
    repeat (4) tick();
    T = 8'h20; expect_wr(2'd1, 8'h3C);
    repeat (3) tick();
    T = 8'h00; tick();
    chk("level_q1", {24'd0, Q1}, 32'h3C);
    chk("level_ovf", {31'd0, ovf}, 32'd0);
    chk("level_busy", {31'd0, busy}, 32'd0);

    // Overwrite before commit sets sticky ovf
    do_reset();
    addr = 2'd0; DIN = 8'h11; T = 8'h08; tick();
    T = 8'h00; tick();
    addr = 2'd3; DIN = 8'h77; T = 8'h08; tick();
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    T = 8'h00; tick();
    T = 8'h20; expect_wr(2'd3, 8'h77); tick();
    chk("ovf_q3", {24'd0, Q3}, 32'h77);
    chk("ovf_q0", {24'd0, Q0}, 32'h00);
    T = 8'h00;
    repeat (10) tick();
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);

    // Simultaneous capture and commit while HELD
    do_reset();
    addr = 2'd0; DIN = 8'h22; T = 8'h08; tick();
    T = 8'h00; tick();
    addr = 2'd1; DIN = 8'h99; T = 8'h28; expect_wr(2'd0, 8'h22); tick();
    chk("sim_q0", {24'd0, Q0}, 32'h22);
    chk("sim_busy", {31'd0, busy}, 32'd1);
    chk("sim_ovf", {31'd0, ovf}, 32'd0);
    T = 8'h00; tick();
    T = 8'h20; expect_wr(2'd1, 8'h99); tick();
    chk("sim_q1", {24'd0, Q1}, 32'h99);
    chk("sim_busy_done", {31'd0, busy}, 32'd0);
    T = 8'h00; tick();

    // Reset discards a held word; stray commits in IDLE do nothing
    do_reset();
    addr = 2'd2; DIN = 8'hFF; T = 8'h08; tick();
    T = 8'h00; rst = 1'b1; tick();
    rst = 1'b0; T = 8'h20; tick();
    chk("mid_rst_q2", {24'd0, Q2}, 32'd0);
    chk("mid_rst_we", {28'd0, WE}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    T = 8'h00; tick();
    T = 8'h20; tick();
    T = 8'h00; tick();
    chk("stray_q", {Q3, Q2, Q1, Q0}, 32'd0);
    chk("stray_busy", {31'd0, busy}, 32'd0);

    chk("sb_drain", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/distributor1to4.md
Name: distributor1to4

Overview:
- Write-side counterpart of the 4-to-1 read selector in the model computer datapath.
- Takes one data word from the internal bus plus a 2-bit destination address, and distributes it into one of four WIDTH-bit holding registers Q0..Q3.
- Capture and commit are sequenced by the timing-pulse vector T.
- Q0..Q3 feed the selector's D0..D3 inputs; WE gives per-register write strobes to downstream logic.

Parameters:
- WIDTH, 8, data width of DIN and Q0..Q3
- TW, 8, width of timing-pulse vector T
- CAP_BIT, 3, index of the T bit that captures addr/DIN
- COMMIT_BIT, 5, index of the T bit that commits the captured word

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst  input  1  synchronous reset, active-high
- T  input  TW  timing-pulse vector from the control sequencer
- addr  input  2  destination register select (00→Q0 … 11→Q3)
- DIN  input  WIDTH  data word from the internal bus
- Q0  output  WIDTH  holding register 0 (registered)
- Q1  output  WIDTH  holding register 1 (registered)
- Q2  output  WIDTH  holding register 2 (registered)
- Q3  output  WIDTH  holding register 3 (registered)
- WE  output  4  one-hot write strobe; bit n high for exactly one cycle when Qn is written
- busy  output  1  high while a captured word awaits commit
- ovf  output  1  sticky: a capture overwrote an uncommitted word

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset, sampled at a posedge with rst=1:
  - Q0..Q3 = 0, WE = 0, busy = 0, ovf = 0.
  - State = IDLE; capture latches and the previous-T register are cleared to 0.
  - rst has priority over every other event.
  - Reset during HELD discards the held word; no write occurs.
- Edge detection:
  - cap_ev = T[CAP_BIT] & ~T_prev[CAP_BIT]; com_ev is defined the same way on COMMIT_BIT.
  - T_prev is registered every cycle.
  - A T bit held high for several cycles produces exactly one event.
  - A T bit already high on the first cycle after reset counts as an event on that cycle.
- FSM states: IDLE, HELD.
- IDLE:
  - cap_ev: latch addr→a_l, DIN→d_l; go to HELD. busy=1 from the next cycle.
  - com_ev alone: ignored; no write, no flag.
  - cap_ev and com_ev on the same cycle: capture only; go to HELD.
- HELD:
  - com_ev, no cap_ev: Q[a_l] <= d_l; WE <= onehot(a_l); go to IDLE; busy=0 next cycle.
  - cap_ev, no com_ev: re-latch a_l/d_l with new values; stay HELD; ovf <= 1.
  - Both on the same cycle: commit the OLD a_l/d_l (Q write and WE pulse), then latch the new addr/DIN; stay HELD; ovf unchanged.
- Latency and strobe timing:
  - Q and WE update at the same posedge. WE clears at the following posedge unless another commit occurs.
  - Write latency: commit edge → Q visible next cycle. Capture edge → earliest commit is one cycle later.
- Only one Q register changes per commit. Other Q registers hold their values indefinitely.
- ovf clears only on rst.
- Data is stored unmodified; there is no arithmetic and no width conversion.

Decomposition:
- Shared package (model computer constants):
  - T-phase indices CAP_BIT = 3 and COMMIT_BIT = 5.
  - State encoding IDLE = 1'b0, HELD = 1'b1.
  - 2-bit register-address constants REG0..REG3.
- One sub-module: t_edge.
  - Parameterised by TW; registers T and outputs a TW-wide rising-edge pulse vector.
  - Synchronous active-high reset.
  - Reused by other T-driven blocks.

Test Plan:
- Reset: rst=1 for 2 cycles with T=0 → Q0..Q3=0, WE=0, busy=0, ovf=0.
- Basic write: addr=2, DIN=8'hA5, pulse T[3] for 1 cycle, then T[5] 2 cycles later:
  - Q2=8'hA5 one cycle after the commit edge.
  - WE=4'b0100 for exactly 1 cycle.
  - busy high between capture and commit.
  - Q0, Q1, Q3 stay at 0.
- Level-held pulse: T[3] held high 4 cycles with addr=1, DIN=8'h3C, then T[5] held high 3 cycles → one write, Q1=8'h3C, WE=4'b0010 for one cycle only, ovf=0.
- Overwrite: capture addr=0/8'h11, then capture addr=3/8'h77 before commit, then commit → Q3=8'h77, Q0 unchanged, ovf=1 and still 1 after 10 more idle cycles.
- Simultaneous events in HELD: held addr=0/8'h22; T[3] and T[5] rise together with addr=1/8'h99:
  - Q0=8'h22, WE=4'b0001, state stays HELD.
  - A later T[5] alone writes Q1=8'h99.
- Reset mid-operation and stray commit: capture addr=2/8'hFF, assert rst for 1 cycle, then pulse T[5] → no write, Q2=0, WE=0, busy=0. A stray T[5] in IDLE also produces no write.
